// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU opcodes, forwarding selects, FSM states.
package ex_pkg;

  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned FWD_W   = 2;

  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b1001;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'b1010;
  localparam logic [ALUOP_W-1:0] ALU_MUL = 4'b1011;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier: loads on i_start, presents the low WIDTH product bits on
// o_product_c while o_done_c is high, and holds there until i_ack.
module ex_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ack,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_product_c
);

  localparam int unsigned        CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_partial;

  assign w_partial = r_b[0] ? r_a : '0;

  // The final partial product is added combinationally so the result is ready
  // exactly WIDTH edges after the start edge.
  assign o_done_c    = r_busy && (r_cnt == LAST);
  assign o_product_c = r_acc + w_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != LAST) begin
        r_acc <= r_acc + w_partial;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_ack) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered MIPS execute stage: forwarding muxes, ALU, valid/ready output register.
// Define EX_MUL_EN to compile in the iterative multiplier and its MUL state.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [WIDTH-1:0]      ReadData1,
  input  logic [WIDTH-1:0]      ReadData2,
  input  logic [WIDTH-1:0]      SignExtImm,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic [REG_ADDR_W-1:0] Rd,
  input  logic [ALUOP_W-1:0]    ALUOp,
  input  logic                  RegDst,
  input  logic                  ALUSrc,
  input  logic [FWD_W-1:0]      ForwardA,
  input  logic [FWD_W-1:0]      ForwardB,
  input  logic [WIDTH-1:0]      ExMemResult,
  input  logic [WIDTH-1:0]      MemWbResult,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WIDTH-1:0]      ALUResult,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  Busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]      w_src_a;
  logic [WIDTH-1:0]      w_fwd_b;
  logic [WIDTH-1:0]      w_src_b;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [WIDTH-1:0]      w_alu_result;
  logic [REG_ADDR_W-1:0] w_wreg;
  logic                  w_accept;
  logic                  w_out_free;
  logic                  w_busy;
  logic                  w_load;
  logic [WIDTH-1:0]      w_load_result;
  logic [REG_ADDR_W-1:0] w_load_wreg;

  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_alu_result;
  logic [REG_ADDR_W-1:0] r_write_reg;

  // Operand forwarding; 11 falls back to the register file like 00.
  always_comb begin
    w_src_a = ReadData1;
    if (ForwardA == FWD_EXMEM)      w_src_a = ExMemResult;
    else if (ForwardA == FWD_MEMWB) w_src_a = MemWbResult;
    w_fwd_b = ReadData2;
    if (ForwardB == FWD_EXMEM)      w_fwd_b = ExMemResult;
    else if (ForwardB == FWD_MEMWB) w_fwd_b = MemWbResult;
  end

  assign w_src_b = ALUSrc ? SignExtImm : w_fwd_b;
  assign w_shamt = w_src_b[SHAMT_W-1:0];
  assign w_wreg  = RegDst ? Rd : Rt;

  // Single-cycle ALU; mul and unknown codes yield zero here.
  always_comb begin
    w_alu_result = '0;
    case (ALUOp)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
      ALU_NOR: w_alu_result = ~(w_src_a | w_src_b);
      ALU_SLT: w_alu_result = WIDTH'($signed(w_src_a) < $signed(w_src_b));
      ALU_SLL: w_alu_result = w_src_a << w_shamt;
      ALU_SRL: w_alu_result = w_src_a >> w_shamt;
      ALU_SRA: w_alu_result = WIDTH'($signed(w_src_a) >>> w_shamt);
      default: w_alu_result = '0;
    endcase
  end

  assign w_out_free = !r_out_valid || OutReady;
  assign InReady    = !w_busy && w_out_free;
  assign w_accept   = InValid && InReady;

`ifdef EX_MUL_EN
  logic                  w_is_mul;
  logic                  w_mul_start;
  logic                  w_mul_done_c;
  logic                  w_mul_load;
  logic [WIDTH-1:0]      w_mul_product;
  ex_state_e             r_state;
  logic                  r_busy;
  logic [REG_ADDR_W-1:0] r_mul_wreg;

  assign w_is_mul    = (ALUOp == ALU_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_mul_load  = (r_state == ST_MUL) && w_mul_done_c && w_out_free;

  ex_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_mul_start),
    .i_a         (w_src_a),
    .i_b         (w_src_b),
    .i_ack       (w_mul_load),
    .o_done_c    (w_mul_done_c),
    .o_product_c (w_mul_product)
  );

  // Stage stays in MUL until the product has been handed to the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_mul_wreg <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_start) begin
            r_state    <= ST_MUL;
            r_busy     <= 1'b1;
            r_mul_wreg <= w_wreg;
          end
        end
        ST_MUL: begin
          if (w_mul_load) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_busy        = r_busy;
  assign w_load        = (w_accept && !w_is_mul) || w_mul_load;
  assign w_load_result = w_mul_load ? w_mul_product : w_alu_result;
  assign w_load_wreg   = w_mul_load ? r_mul_wreg : w_wreg;
`else
  assign w_busy        = 1'b0;
  assign w_load        = w_accept;
  assign w_load_result = w_alu_result;
  assign w_load_wreg   = w_wreg;
`endif

  // A load on the same edge as a drain keeps OutValid high with the new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_alu_result <= w_load_result;
      r_write_reg  <= w_load_wreg;
    end else if (OutReady) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign OutValid  = r_out_valid;
  assign ALUResult = r_alu_result;
  assign WriteReg  = r_write_reg;
  assign Busy      = w_busy;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed cases plus randomized traffic
// checked against a behavioural ALU model.
module tb_ex_stage_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst_n;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  ReadData1;
  logic [W-1:0]  ReadData2;
  logic [W-1:0]  SignExtImm;
  logic [RW-1:0] Rt;
  logic [RW-1:0] Rd;
  logic [3:0]    ALUOp;
  logic          RegDst;
  logic          ALUSrc;
  logic [1:0]    ForwardA;
  logic [1:0]    ForwardB;
  logic [W-1:0]  ExMemResult;
  logic [W-1:0]  MemWbResult;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  ALUResult;
  logic [RW-1:0] WriteReg;
  logic          Busy;

  int checks   = 0;
  int failures = 0;
  bit rand_or  = 1'b0;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [RW-1:0] wreg;
  } exp_t;

  exp_t sb[$];

  logic [3:0] ops [13] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7,
                           4'h8, 4'h9, 4'hA, 4'hB, 4'hF, 4'h4};

  ex_stage_pipe #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .SignExtImm  (SignExtImm),
    .Rt          (Rt),
    .Rd          (Rd),
    .ALUOp       (ALUOp),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .ExMemResult (ExMemResult),
    .MemWbResult (MemWbResult),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .ALUResult   (ALUResult),
    .WriteReg    (WriteReg),
    .Busy        (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [1:0] f, input logic [W-1:0] rf,
                                        input logic [W-1:0] exm, input logic [W-1:0] mwb);
    if (f == 2'b10) return exm;
    if (f == 2'b01) return mwb;
    return rf;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned  sh;
    logic [W-1:0] ones;
    sh   = b % W;
    ones = '1;
    case (op)
      4'h2: return a + b;
      4'h6: return a - b;
      4'h0: return a & b;
      4'h1: return a | b;
      4'h3: return a ^ b;
      4'hC: return ~(a | b);
      4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: return a << sh;
      4'h9: return a >> sh;
      4'hA: return (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0);
`ifdef EX_MUL_EN
      4'hB: begin
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
`endif
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic step_or();
    if (rand_or) OutReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      step_or();
    end
  endtask

  // Presents one instruction until accepted; pushes the model result at accept.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                       input logic [W-1:0] imm, input logic [W-1:0] exm, input logic [W-1:0] mwb,
                       input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                       input logic regdst, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       output int stalls);
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a      = pick(fa, rd1, exm, mwb);
    b      = alusrc ? imm : pick(fb, rd2, exm, mwb);
    e.res  = ref_alu(op, a, b);
    e.wreg = regdst ? rd : rt;
    ALUOp = op; ReadData1 = rd1; ReadData2 = rd2; SignExtImm = imm;
    ExMemResult = exm; MemWbResult = mwb; ForwardA = fa; ForwardB = fb;
    ALUSrc = alusrc; RegDst = regdst; Rt = rt; Rd = rd; InValid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (InReady) break;
      stalls++;
      if (stalls > 500) begin
        checks++; failures++;
        $display("FAIL issue_timeout stalls=%0d required=<=500", stalls);
        break;
      end
      @(posedge clk); #1;
      step_or();
    end
    if (InReady) sb.push_back(e);
    @(posedge clk); #1;
    InValid = 1'b0;
    ReadData1 = $urandom; ReadData2 = $urandom; SignExtImm = $urandom;
    ExMemResult = $urandom; MemWbResult = $urandom; ALUOp = 4'($urandom);
    ForwardA = 2'($urandom); ForwardB = 2'($urandom); ALUSrc = 1'($urandom);
    RegDst = 1'($urandom); Rt = RW'($urandom); Rd = RW'($urandom);
    step_or();
  endtask

  // Scoreboard monitor: a result transfers on the edge after OutValid && OutReady.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && OutValid && OutReady) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got=%h/%0d required=no_output", ALUResult, WriteReg);
      end else begin
        e = sb.pop_front();
        if (ALUResult !== e.res || WriteReg !== e.wreg) begin
          failures++;
          $display("FAIL out_result got=%h/%0d required=%h/%0d", ALUResult, WriteReg,
                   e.res, e.wreg);
        end
      end
    end
  end

  initial begin
    int s, s0, s1, s2, bc, bad, t;
    logic [3:0] op;
    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    ReadData1 = '0; ReadData2 = '0; SignExtImm = '0; Rt = '0; Rd = '0; ALUOp = '0;
    RegDst = 1'b0; ALUSrc = 1'b0; ForwardA = '0; ForwardB = '0;
    ExMemResult = '0; MemWbResult = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outvalid", W'(OutValid), 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_wreg", W'(WriteReg), 32'd0);
    chk("rst_busy", W'(Busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_inready", W'(InReady), 32'd1);
    @(posedge clk); #1;

    // Back-to-back add / sub / slt
    OutReady = 1'b1;
    issue(4'h2, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, s0);
    issue(4'h6, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3, 5'd4, s1);
    issue(4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd5, 5'd6, s2);
    chk("b2b_stalls", W'(s0 + s1 + s2), 32'd0);

    // Forwarding
    issue(4'h2, 32'h1, 32'h77, 32'h4, 32'h100, 32'h55, 2'b10, 2'b00, 1'b1, 1'b1, 5'd7, 5'd8, s);
    issue(4'h2, 32'd10, 32'h77, 32'd7, 32'h99, 32'hDEAD, 2'b00, 2'b01, 1'b1, 1'b0, 5'd9, 5'd10, s);
    issue(4'h6, 32'h50, 32'h3, 32'd0, 32'h10, 32'h20, 2'b11, 2'b10, 1'b0, 1'b1, 5'd11, 5'd12, s);
    issue(4'h1, 32'h1, 32'h3, 32'd0, 32'hF0, 32'hF00, 2'b01, 2'b01, 1'b0, 1'b1, 5'd13, 5'd14, s);

    // Shifts, logic ops and unknown opcode
    issue(4'hA, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd15, s);
    issue(4'h9, 32'h8000_0000, 32'h3F, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd16, s);
    issue(4'h8, 32'h0000_0001, 32'h0, 32'd31, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd0, 5'd17, s);
    issue(4'hC, 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd18, 5'd0, s);
    issue(4'hF, 32'h1234_5678, 32'h1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd19, s);

    // Back-pressure: result and destination hold, no accept while blocked
    idle(2);
    OutReady = 1'b0;
    issue(4'h2, 32'h11, 32'h22, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd2, 5'd9, s);
    InValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_inready", W'(InReady), 32'd0);
      chk("bp_outvalid", W'(OutValid), 32'd1);
      chk("bp_result", ALUResult, 32'h33);
      chk("bp_wreg", W'(WriteReg), 32'd9);
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    issue(4'h3, 32'hFF00, 32'h0FF0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd21, 5'd1, s);
    chk("bp_drain_stalls", W'(s), 32'd0);
    @(negedge clk);
    chk("bp_same_edge_valid", W'(OutValid), 32'd1);
    chk("bp_same_edge_result", ALUResult, 32'h0000_F0F0);
    @(posedge clk); #1;

`ifdef EX_MUL_EN
    idle(2);
    issue(4'hB, 32'h0001_0003, 32'h5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd22, s);
    bc = 0; bad = 0;
    @(negedge clk);
    while (Busy && bc < 200) begin
      bc++;
      if (InReady) bad++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", W'(bc), 32'd32);
    chk("mul_inready_low", W'(bad), 32'd0);
    chk("mul_outvalid", W'(OutValid), 32'd1);
    chk("mul_product", ALUResult, 32'h0005_000F);
    @(posedge clk); #1;

    idle(2);
    issue(4'hB, 32'h1234, 32'h5678, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd23, s);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mulrst_outvalid", W'(OutValid), 32'd0);
    chk("mulrst_busy", W'(Busy), 32'd0);
    chk("mulrst_result", ALUResult, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (OutValid || Busy) bad++;
    end
    chk("mulrst_no_output", W'(bad), 32'd0);
    @(posedge clk); #1;
`else
    issue(4'hB, 32'h0001_0003, 32'h5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd22, s);
    @(negedge clk);
    chk("mul_off_busy", W'(Busy), 32'd0);
    chk("mul_off_outvalid", W'(OutValid), 32'd1);
    chk("mul_off_result", ALUResult, 32'd0);
    @(posedge clk); #1;
`endif

    // Randomized traffic with random back-pressure and issue gaps
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 12)];
      issue(op, $urandom, $urandom, $urandom, $urandom, $urandom,
            2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            RW'($urandom), RW'($urandom), s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_or = 1'b0;
    OutReady = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", W'(sb.size()), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
